// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the two requester ports and the Memory-side bus.
//   slave  modport: arbiter view (requests + mem_out in, acks/data/mem bus out)
//   master modport: requester/memory view (mirror of slave)
//   req0/req1, we0/we1, addr0/addr1, wdata0/wdata1 : per-port request
//   ack0/ack1, rdata, grant, busy                  : per-port completion/status
//   mem_address, mem_load, mem_in, mem_out         : single-port Memory bus
interface mem_arbiter_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             req0;
  logic             req1;
  logic             we0;
  logic             we1;
  logic [WIDTH-1:0] addr0;
  logic [WIDTH-1:0] addr1;
  logic [WIDTH-1:0] wdata0;
  logic [WIDTH-1:0] wdata1;
  logic             ack0;
  logic             ack1;
  logic [WIDTH-1:0] rdata;
  logic [1:0]       grant;
  logic             busy;
  logic [WIDTH-1:0] mem_address;
  logic             mem_load;
  logic [WIDTH-1:0] mem_in;
  logic [WIDTH-1:0] mem_out;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_out,
    output ack0, ack1, rdata, grant, busy, mem_address, mem_load, mem_in
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_out,
    input  ack0, ack1, rdata, grant, busy, mem_address, mem_load, mem_in
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter/sequencer in front of a single-port
// Memory with fixed read latency RD_LAT (0..3, 0 = combinational read).
//   clk   : clock, all state changes on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mem_arbiter_if.slave (port 0 = CPU data, port 1 = debug/loader,
//           plus the mem_address/mem_load/mem_in/mem_out Memory bus)
// Sequence per transaction: IDLE (sample) -> ISSUE -> [WAIT x RD_LAT] -> DONE.
// All outputs are registers; nothing combinational from req to any output.
module mem_arbiter #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned RD_LAT = 1
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [1:0]         ack_q, ack_d;
  logic [WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]         grant_q, grant_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   addr_q, addr_d;
  logic               load_q, load_d;
  logic [WIDTH-1:0]   din_q, din_d;
  logic               win;

  // Next-state and next-output logic; every register's next value is formed here.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    ack_d   = 2'b00;
    rdata_d = rdata_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    load_d  = 1'b0;
    din_d   = din_q;
    win     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // On a tie the port that did not go last wins; win = 1 means port 1.
          win     = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
          state_d = ISSUE;
          last_d  = win;
          grant_d = win ? 2'b10 : 2'b01;
          addr_d  = win ? bus.addr1  : bus.addr0;
          din_d   = win ? bus.wdata1 : bus.wdata0;
          we_d    = win ? bus.we1    : bus.we0;
          load_d  = win ? bus.we1    : bus.we0;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = DONE;
          rdata_d = '0;
          ack_d   = grant_q;
        end else if (RD_LAT == 0) begin
          state_d = DONE;
          rdata_d = bus.mem_out;
          ack_d   = grant_q;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(RD_LAT);
        end
      end
      WAIT: begin
        // Capture on the edge that ends the last of RD_LAT wait cycles.
        if (cnt_q <= CNT_W'(1)) begin
          state_d = DONE;
          rdata_d = bus.mem_out;
          ack_d   = grant_q;
        end else begin
          cnt_d = CNT_W'(cnt_q - CNT_W'(1));
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      ack_q   <= 2'b00;
      rdata_q <= '0;
      grant_q <= 2'b00;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      load_q  <= 1'b0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      load_q  <= load_d;
      din_q   <= din_d;
    end
  end

  assign bus.ack0        = ack_q[0];
  assign bus.ack1        = ack_q[1];
  assign bus.rdata       = rdata_q;
  assign bus.grant       = grant_q;
  assign bus.busy        = busy_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_load    = load_q;
  assign bus.mem_in      = din_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with RD_LAT = 1.
// A transaction-level reference (ideal memory + round-robin order) pushes the
// expected response per port; a monitor pops and compares on every ack.
module tb_mem_arbiter;

  localparam int unsigned W   = 16;
  localparam int unsigned LAT = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.WIDTH(W)) bus ();

  mem_arbiter #(.WIDTH(W), .RD_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: RAM + LED at 8192 + button at 8193, one-cycle registered read.
  bit [W-1:0] ram [0:65535];
  bit         led;
  logic       btn = 1'b0;
  always @(posedge clk) begin
    if (bus.mem_load) begin
      if (bus.mem_address == 16'd8192)      led <= bus.mem_in[0];
      else if (bus.mem_address != 16'd8193) ram[bus.mem_address] <= bus.mem_in;
    end
    if (bus.mem_address == 16'd8192)      bus.mem_out <= {15'd0, led};
    else if (bus.mem_address == 16'd8193) bus.mem_out <= {15'd0, btn};
    else                                  bus.mem_out <= ram[bus.mem_address];
  end

  // Reference model state: ideal memory contents and who was served last.
  bit [W-1:0] shadow [0:65535];
  bit         ref_led;
  int         ref_last = 1;

  typedef struct {
    logic         we;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic [W-1:0] rdata;
    int unsigned  cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] ref_read(input logic [W-1:0] a);
    if (a == 16'd8192) return {15'd0, ref_led};
    if (a == 16'd8193) return {15'd0, btn};
    return shadow[a];
  endfunction

  task automatic ref_write(input logic [W-1:0] a, input logic [W-1:0] d);
    if (a == 16'd8192)      ref_led = d[0];
    else if (a != 16'd8193) shadow[a] = d;
  endtask

  // One round: raise the selected requests now (just after an edge), predict
  // service order and ack cycles, then hold each req until its own ack.
  task automatic do_round(input bit u0, input bit w0, input logic [W-1:0] a0,
                          input logic [W-1:0] d0, input bit u1, input bit w1,
                          input logic [W-1:0] a1, input logic [W-1:0] d1);
    int          first;
    int unsigned issue_cyc;
    exp_t        e;
    bit          p0, p1, s0, s1;
    int          budget;
    if (!u0 && !u1) return;
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_grant", 32'(bus.grant), 32'd0);
    first     = (u0 && u1) ? ((ref_last == 1) ? 0 : 1) : (u1 ? 1 : 0);
    issue_cyc = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      int p;
      p = (k == 0) ? first : 1 - first;
      if ((p == 0 && u0) || (p == 1 && u1)) begin
        e.we    = (p == 1) ? w1 : w0;
        e.addr  = (p == 1) ? a1 : a0;
        e.wdata = (p == 1) ? d1 : d0;
        e.rdata = e.we ? '0 : ref_read(e.addr);
        if (e.we) ref_write(e.addr, e.wdata);
        e.cyc   = issue_cyc + 1 + (e.we ? 0 : LAT);
        if (p == 0) q0.push_back(e);
        else        q1.push_back(e);
        ref_last  = p;
        issue_cyc = e.cyc + 2;
      end
    end
    bus.req0 = u0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = u1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    p0 = u0; p1 = u1; budget = 0;
    while ((p0 || p1) && budget < 40) begin
      @(negedge clk);
      s0 = bus.ack0;
      s1 = bus.ack1;
      @(posedge clk); #1;
      if (s0) begin p0 = 1'b0; bus.req0 = 1'b0; end
      if (s1) begin p1 = 1'b0; bus.req1 = 1'b0; end
      budget++;
    end
    chk("round_complete", {30'd0, p0, p1}, 32'd0);
    if (p0 || p1) begin
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      q0.delete();
      q1.delete();
    end
  endtask

  // Monitor: count mem_load cycles per transaction; check each ack against the queue.
  int unsigned  load_cnt = 0;
  logic [W-1:0] load_addr, load_din;

  task automatic check_port(input int p);
    exp_t e;
    if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_ack port %0d: got ack with nothing pending (cycle %0d)", p, cyc);
      return;
    end
    e = (p == 0) ? q0.pop_front() : q1.pop_front();
    chk($sformatf("grant_p%0d", p), 32'(bus.grant), (p == 1) ? 32'd2 : 32'd1);
    chk($sformatf("busy_done_p%0d", p), 32'(bus.busy), 32'd1);
    chk($sformatf("rdata_p%0d", p), 32'(bus.rdata), 32'(e.rdata));
    chk($sformatf("ack_cycle_p%0d", p), cyc, e.cyc);
    chk($sformatf("load_cycles_p%0d", p), load_cnt, e.we ? 32'd1 : 32'd0);
    if (e.we) begin
      chk($sformatf("load_addr_p%0d", p), 32'(load_addr), 32'(e.addr));
      chk($sformatf("load_data_p%0d", p), 32'(load_din), 32'(e.wdata));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        load_cnt = 0;
      end else begin
        if (bus.mem_load) begin
          load_cnt++;
          load_addr = bus.mem_address;
          load_din  = bus.mem_in;
        end
        if (bus.ack0 || bus.ack1) begin
          chk("ack_overlap", 32'(bus.ack0 & bus.ack1), 32'd0);
          if (bus.ack0) check_port(0);
          if (bus.ack1) check_port(1);
          load_cnt = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  logic [W-1:0] pool [8] = '{16'd0, 16'd1, 16'd2, 16'd5, 16'd100, 16'd200, 16'h3FFF, 16'hFFFF};

  function automatic logic [W-1:0] pick_addr();
    int unsigned s;
    s = $urandom_range(0, 9);
    if (s < 7)  return pool[$urandom_range(0, 7)];
    if (s == 7) return 16'd8192;
    if (s == 8) return 16'd8193;
    return W'($urandom);
  endfunction

  initial begin
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;

    // Reset held two cycles; all outputs at reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", {30'd0, bus.ack0, bus.ack1}, 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_mem_address", 32'(bus.mem_address), 32'd0);
    chk("rst_mem_load", 32'(bus.mem_load), 32'd0);
    chk("rst_mem_in", 32'(bus.mem_in), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single write, then read-back from the other port.
    do_round(1, 1, 16'd0, 16'h7FFF, 0, 0, '0, '0);
    do_round(0, 0, '0, '0, 1, 0, 16'd0, '0);

    // LED / button path.
    do_round(1, 1, 16'd8192, 16'd1, 0, 0, '0, '0);
    chk("led_on", 32'(led), 32'd1);
    btn = 1'b1;
    do_round(1, 0, 16'd8193, '0, 0, 0, '0, '0);
    do_round(1, 1, 16'd8192, 16'd0, 0, 0, '0, '0);
    chk("led_off", 32'(led), 32'd0);

    // Contention: port 1 served last, so grants run 0,1,0,1.
    do_round(0, 0, '0, '0, 1, 1, 16'd5, 16'h1234);
    do_round(1, 0, 16'd0, '0, 1, 0, 16'd5, '0);
    do_round(1, 0, 16'd5, '0, 1, 0, 16'd0, '0);

    // Reset in the middle of a port 1 read.
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'd8193;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_grant", 32'(bus.grant), 32'd0);
    chk("mid_rst_ack1", 32'(bus.ack1), 32'd0);
    chk("mid_rst_mem_load", 32'(bus.mem_load), 32'd0);
    bus.req1 = 1'b0;
    ref_last = 1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_ack_after_reset", {30'd0, bus.ack0, bus.ack1}, 32'd0);
    end
    @(posedge clk); #1;
    do_round(1, 0, 16'd0, '0, 1, 0, 16'd5, '0);

    // Write then immediate read of the same word from the other port.
    do_round(1, 1, 16'd100, 16'hFFFF, 0, 0, '0, '0);
    do_round(0, 0, '0, '0, 1, 0, 16'd100, '0);

    // Randomized traffic.
    for (int r = 0; r < 200; r++) begin
      int unsigned mode;
      if ($urandom_range(0, 7) == 0) btn = ~btn;
      mode = $urandom_range(0, 2);
      do_round(mode != 1, 1'($urandom), pick_addr(), W'($urandom),
               mode != 0, 1'($urandom), pick_addr(), W'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    #1;
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
